multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the single-ALU RISC-V (RV32I subset) datapath. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB states. In each state it drives the ALU operand selects, ALUOp and PCSrc, the PC/IR/register-file write enables, and the memory request handshakes. The instruction word comes from the external IR; `funct3`/`funct7` go straight from the IR to the ALU.

---
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle instruction sequencer for the single-ALU RV32I datapath.
// Each instruction is walked through FETCH/DECODE/EXEC/MEM/WB. During DECODE the opcode
// is reduced to an instruction class. All later outputs are decoded from the state plus
// that latched class, so they do not depend on the IR contents after DECODE.
module multicycle_ctrl #(
    parameter int RESET_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            inst,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    input  logic                   zero,
    output logic                   imem_req,
    output logic                   ir_we,
    output logic                   dmem_re,
    output logic                   dmem_we,
    output logic                   reg_we,
    output logic                   wb_sel,
    output logic                   pc_we,
    output logic                   pc_sel,
    output logic [1:0]             ALUSrc,
    output logic [1:0]             ALUSrc1,
    output logic                   PCSrc,
    output logic [1:0]             ALUOp,
    output logic                   illegal,
    output logic [RESET_CNT_W-1:0] instret
);

    // Operand-select and ALU operation encodings shared with the datapath
    localparam logic [1:0] SRC_REG   = 2'd0;
    localparam logic [1:0] SRC_IMM   = 2'd1;
    localparam logic [1:0] SRC_ZERO  = 2'd2;
    localparam logic [1:0] SRC_FOUR  = 2'd3;
    localparam logic [1:0] SRC1_REG  = 2'd0;
    localparam logic [1:0] SRC1_ZERO = 2'd1;
    localparam logic [1:0] SRC1_PC   = 2'd2;
    localparam logic       PCSRC_PPC = 1'b1;
    localparam logic       PCSRC_RS1 = 1'b0;
    localparam logic [1:0] OP_R      = 2'd0;
    localparam logic [1:0] OP_I      = 2'd1;
    localparam logic [1:0] OP_J      = 2'd2;
    localparam logic [1:0] OP_BRANCH = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
    } class_e;

    state_e                  state_q, state_d;
    class_e                  class_q, class_d;
    logic [RESET_CNT_W-1:0]  instret_q, instret_d;
    logic                    pc_we_int;
    logic                    alu_hold;
    logic                    unused_inst;

    // Only the opcode field is consumed here; funct3/funct7 go directly to the ALU
    assign unused_inst = ^inst[31:7];

    // State, latched class and retired-instruction counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            class_q   <= C_R;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic; the class is captured from the opcode only in DECODE
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (inst[6:0])
                    7'b0110011: class_d = C_R;
                    7'b0010011: class_d = C_I;
                    7'b0000011: class_d = C_LOAD;
                    7'b0100011: class_d = C_STORE;
                    7'b1100011: class_d = C_BR;
                    7'b1101111: class_d = C_JAL;
                    7'b1100111: class_d = C_JALR;
                    7'b0110111: class_d = C_LUI;
                    7'b0010111: class_d = C_AUIPC;
                    default:    class_d = C_ILL;
                endcase
                if (class_d == C_ILL) state_d = S_TRAP;
                else                  state_d = S_EXEC;
            end
            S_EXEC: begin
                if (class_q == C_BR)                               state_d = S_FETCH;
                else if ((class_q == C_LOAD) || (class_q == C_STORE)) state_d = S_MEM;
                else                                               state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (class_q == C_STORE) state_d = S_FETCH;
                    else                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Retired-instruction count advances on every PC update and wraps naturally
    always_comb begin
        instret_d = instret_q + RESET_CNT_W'(pc_we_int);
    end

    // Output decode from state and class; an asserted reset suppresses every enable
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        pc_we_int = 1'b0;
        pc_sel    = 1'b0;
        ALUSrc    = SRC_REG;
        ALUSrc1   = SRC1_REG;
        ALUOp     = OP_R;
        PCSrc     = PCSRC_PPC;
        alu_hold  = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
        if (!rst) begin
            if (alu_hold) begin
                case (class_q)
                    C_R:     begin ALUSrc1 = SRC1_REG;  ALUSrc = SRC_REG;  ALUOp = OP_R;      end
                    C_I:     begin ALUSrc1 = SRC1_REG;  ALUSrc = SRC_IMM;  ALUOp = OP_I;      end
                    C_LOAD,
                    C_STORE: begin ALUSrc1 = SRC1_REG;  ALUSrc = SRC_IMM;  ALUOp = OP_J;      end
                    C_LUI:   begin ALUSrc1 = SRC1_ZERO; ALUSrc = SRC_IMM;  ALUOp = OP_J;      end
                    C_AUIPC: begin ALUSrc1 = SRC1_PC;   ALUSrc = SRC_IMM;  ALUOp = OP_J;      end
                    C_BR:    begin ALUSrc1 = SRC1_REG;  ALUSrc = SRC_REG;  ALUOp = OP_BRANCH; end
                    C_JAL:   begin ALUSrc1 = SRC1_PC;   ALUSrc = SRC_FOUR; ALUOp = OP_J;      end
                    C_JALR:  begin ALUSrc1 = SRC1_PC;   ALUSrc = SRC_FOUR; ALUOp = OP_J;
                                   PCSrc = PCSRC_RS1; end
                    default: ;
                endcase
            end
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    if (class_q == C_BR) begin
                        pc_we_int = 1'b1;
                        pc_sel    = zero;
                    end
                end
                S_MEM: begin
                    dmem_re = (class_q == C_LOAD);
                    dmem_we = (class_q == C_STORE);
                    if (dmem_ready && (class_q == C_STORE)) pc_we_int = 1'b1;
                end
                S_WB: begin
                    reg_we    = 1'b1;
                    pc_we_int = 1'b1;
                    wb_sel    = (class_q == C_LOAD);
                    pc_sel    = (class_q == C_JAL) || (class_q == C_JALR);
                end
                default: ;
            endcase
        end
    end

    assign pc_we   = pc_we_int;
    assign illegal = !rst && (state_q == S_TRAP);
    assign instret = rst ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences against a trace-building model.
// For each instruction the bench derives, from its opcode class and the chosen memory
// wait counts, the full list of per-cycle outputs and queues it; one compare process
// checks the DUT against that queue every cycle.
module tb_multicycle_ctrl;

   typedef enum int {K_R, K_I, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_e;

   typedef struct packed {
      logic imem_req;
      logic ir_we;
      logic dmem_re;
      logic dmem_we;
      logic reg_we;
      logic wb_sel;
      logic pc_we;
      logic pc_sel;
      logic illegal;
      logic [1:0] alu_src;
      logic [1:0] alu_src1;
      logic pc_src;
      logic [1:0] alu_op;
      logic [31:0] instret;
   } obs_t;

   logic clk;
   logic rst;
   logic [31:0] inst;
   logic imem_ready, dmem_ready, zero;
   logic imem_req, ir_we, dmem_re, dmem_we, reg_we, wb_sel, pc_we, pc_sel;
   logic [1:0] ALUSrc, ALUSrc1, ALUOp;
   logic PCSrc, illegal;
   logic [31:0] instret;

   obs_t expQ[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pcWeCyc = 0;
   int cycleNum = 0;
   logic [31:0] modelInstret = 32'd0;

   multicycle_ctrl #(.RESET_CNT_W(32)) dut (
      .clk(clk), .rst(rst), .inst(inst),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
      .imem_req(imem_req), .ir_we(ir_we), .dmem_re(dmem_re), .dmem_we(dmem_we),
      .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
      .ALUSrc(ALUSrc), .ALUSrc1(ALUSrc1), .PCSrc(PCSrc), .ALUOp(ALUOp),
      .illegal(illegal), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Readable rendering of one output vector
   function automatic string fmt(obs_t o);
      return $sformatf("req=%b irwe=%b re=%b we=%b regwe=%b wbsel=%b pcwe=%b pcsel=%b ill=%b src=%0d src1=%0d pcsrc=%b op=%0d instret=%0d",
                       o.imem_req, o.ir_we, o.dmem_re, o.dmem_we, o.reg_we, o.wb_sel, o.pc_we,
                       o.pc_sel, o.illegal, o.alu_src, o.alu_src1, o.pc_src, o.alu_op, o.instret);
   endfunction

   // Opcode to instruction class
   function automatic kind_e classify(logic [31:0] w);
      case (w[6:0])
         7'b0110011: return K_R;
         7'b0010011: return K_I;
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b1100011: return K_BR;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b0110111: return K_LUI;
         7'b0010111: return K_AUIPC;
         default:    return K_ILL;
      endcase
   endfunction

   // Idle outputs: no enables, ALU defaults REG/REG/R/PPC, current retired count
   function automatic obs_t baseObs();
      obs_t o;
      o = '0;
      o.pc_src = 1'b1;
      o.instret = modelInstret;
      return o;
   endfunction

   // ALU operand/op settings for a class (src: 0 REG,1 IMM,2 ZERO,3 four; src1: 0 REG,1 ZERO,2 PC)
   function automatic obs_t withAlu(obs_t oIn, kind_e k);
      obs_t o;
      o = oIn;
      case (k)
         K_R:             begin o.alu_src1 = 2'd0; o.alu_src = 2'd0; o.alu_op = 2'd0; end
         K_I:             begin o.alu_src1 = 2'd0; o.alu_src = 2'd1; o.alu_op = 2'd1; end
         K_LOAD, K_STORE: begin o.alu_src1 = 2'd0; o.alu_src = 2'd1; o.alu_op = 2'd2; end
         K_LUI:           begin o.alu_src1 = 2'd1; o.alu_src = 2'd1; o.alu_op = 2'd2; end
         K_AUIPC:         begin o.alu_src1 = 2'd2; o.alu_src = 2'd1; o.alu_op = 2'd2; end
         K_BR:            begin o.alu_src1 = 2'd0; o.alu_src = 2'd0; o.alu_op = 2'd3; end
         K_JAL:           begin o.alu_src1 = 2'd2; o.alu_src = 2'd3; o.alu_op = 2'd2; end
         K_JALR:          begin o.alu_src1 = 2'd2; o.alu_src = 2'd3; o.alu_op = 2'd2; o.pc_src = 1'b0; end
         default: ;
      endcase
      return o;
   endfunction

   // Compare DUT outputs with the queued expectation at every falling edge
   always @(negedge clk) begin : compareProc
      obs_t act;
      obs_t want;
      cyc = cyc + 1;
      act.imem_req = imem_req;  act.ir_we = ir_we;    act.dmem_re = dmem_re;
      act.dmem_we = dmem_we;    act.reg_we = reg_we;  act.wb_sel = wb_sel;
      act.pc_we = pc_we;        act.pc_sel = pc_sel;  act.illegal = illegal;
      act.alu_src = ALUSrc;     act.alu_src1 = ALUSrc1;
      act.pc_src = PCSrc;       act.alu_op = ALUOp;   act.instret = instret;
      if (pc_we === 1'b1) pcWeCyc = cyc;
      if (expQ.size() > 0) begin
         want = expQ.pop_front();
         checks++;
         if (act !== want) begin
            errors++;
            $display("[TB] FAIL trace cyc=%0d got {%s} want {%s}", cyc, fmt(act), fmt(want));
         end
      end
   end

   // Drive one cycle of inputs and queue what the outputs must be in that cycle
   task automatic applyStimulus(input logic r, input logic ir, input logic dr, input logic z, input obs_t e);
      @(posedge clk);
      #1;
      rst = r;
      imem_ready = ir;
      dmem_ready = dr;
      zero = z;
      expQ.push_back(e);
      cycleNum = cyc + 1;
   endtask

   task automatic checkOutput(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic doReset(input int n);
      modelInstret = 32'd0;
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, baseObs());
   endtask

   // Cycles from the first FETCH cycle to the observed pc_we pulse, inclusive
   task automatic measureCpi(input int startNum, output int cpi);
      @(negedge clk);
      #1;
      cpi = pcWeCyc - startNum + 1;
   endtask

   // Expected trace for one instruction; abortAt >= 0 pulses rst in that MEM cycle
   task automatic runInstr(input logic [31:0] word, input int iwait, input int dwait,
                           input logic zv, input int abortAt, output int cpi);
      kind_e k;
      obs_t e;
      int startNum;
      logic last;
      k = classify(word);
      inst = word;
      cpi = 0;
      startNum = 0;
      for (int w = 0; w <= iwait; w++) begin
         e = baseObs();
         e.imem_req = 1'b1;
         e.ir_we = (w == iwait);
         applyStimulus(1'b0, (w == iwait), 1'b1, ~zv, e);
         if (w == 0) startNum = cycleNum;
      end
      applyStimulus(1'b0, 1'b1, 1'b1, ~zv, baseObs());
      if (k == K_ILL) begin
         for (int t = 0; t < 20; t++) begin
            e = baseObs();
            e.illegal = 1'b1;
            applyStimulus(1'b0, 1'b1, 1'b1, t[0], e);
         end
         return;
      end
      e = withAlu(baseObs(), k);
      if (k == K_BR) begin
         e.pc_we = 1'b1;
         e.pc_sel = zv;
         applyStimulus(1'b0, 1'b1, 1'b1, zv, e);
         modelInstret++;
         measureCpi(startNum, cpi);
         return;
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, e);
      if ((k == K_LOAD) || (k == K_STORE)) begin
         for (int w = 0; w <= dwait; w++) begin
            if (w == abortAt) begin
               modelInstret = 32'd0;
               applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, baseObs());
               return;
            end
            last = (w == dwait);
            e = withAlu(baseObs(), k);
            e.dmem_re = (k == K_LOAD);
            e.dmem_we = (k == K_STORE);
            if (last && (k == K_STORE)) e.pc_we = 1'b1;
            applyStimulus(1'b0, 1'b1, last, ~zv, e);
         end
         if (k == K_STORE) begin
            modelInstret++;
            measureCpi(startNum, cpi);
            return;
         end
      end
      e = withAlu(baseObs(), k);
      e.reg_we = 1'b1;
      e.pc_we = 1'b1;
      e.wb_sel = (k == K_LOAD);
      e.pc_sel = (k == K_JAL) || (k == K_JALR);
      applyStimulus(1'b0, 1'b1, 1'b1, ~zv, e);
      modelInstret++;
      measureCpi(startNum, cpi);
   endtask

   // Directed instruction sequence
   initial begin
      int cpi;
      rst = 1'b1;
      inst = 32'd0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      zero = 1'b0;

      doReset(2);
      runInstr(32'h002081B3, 0, 0, 1'b0, -1, cpi);  checkOutput("cpi_add", cpi, 4);
      checkOutput("model_instret_add", int'(modelInstret), 1);
      runInstr(32'h0000A183, 0, 3, 1'b0, -1, cpi);  checkOutput("cpi_load_wait3", cpi, 8);
      runInstr(32'h00208463, 0, 0, 1'b1, -1, cpi);  checkOutput("cpi_beq_taken", cpi, 3);
      runInstr(32'h00208463, 0, 0, 1'b0, -1, cpi);  checkOutput("cpi_beq_not_taken", cpi, 3);
      runInstr(32'h008000EF, 0, 0, 1'b0, -1, cpi);  checkOutput("cpi_jal", cpi, 4);
      runInstr(32'h00108093, 2, 0, 1'b0, -1, cpi);  checkOutput("cpi_addi_iwait2", cpi, 6);
      runInstr(32'h000010B7, 0, 0, 1'b0, -1, cpi);  checkOutput("cpi_lui", cpi, 4);
      runInstr(32'h00001097, 0, 0, 1'b0, -1, cpi);  checkOutput("cpi_auipc", cpi, 4);
      runInstr(32'h000080E7, 0, 0, 1'b0, -1, cpi);  checkOutput("cpi_jalr", cpi, 4);
      runInstr(32'h0020A023, 0, 1, 1'b0, -1, cpi);  checkOutput("cpi_store_wait1", cpi, 5);
      checkOutput("model_instret_seq", int'(modelInstret), 10);

      runInstr(32'h0000007F, 0, 0, 1'b0, -1, cpi);
      doReset(1);
      checkOutput("model_instret_after_reset", int'(modelInstret), 0);

      runInstr(32'h0020A023, 0, 5, 1'b0, 2, cpi);
      runInstr(32'h002081B3, 0, 0, 1'b0, -1, cpi);  checkOutput("cpi_add_after_abort", cpi, 4);
      checkOutput("model_instret_after_abort", int'(modelInstret), 1);

      @(negedge clk);
      #1;
      checkOutput("trace_queue_drained", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
